// File: rtl/morse_decoder_fifo.sv
// Morse symbol decoder: collects dot/dash pulses per character, enforces char/word gaps,
// translates ITU codes to ASCII and buffers the result in a valid/ready output FIFO.
module morse_decoder_fifo #(
    parameter int unsigned CHAR_GAP     = 3,
    parameter int unsigned WORD_GAP     = 7,
    parameter int unsigned MAX_SYMS     = 5,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dot_inp,
    input  logic                          dash_inp,
    input  logic                          char_space_inp,
    input  logic                          word_space_inp,
    output logic [7:0]                    sout,
    output logic                          sout_valid,
    input  logic                          sout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_protocol,
    output logic                          overflow
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned CW   = 4;
    localparam int unsigned GMAX = (CHAR_GAP > WORD_GAP) ? CHAR_GAP : WORD_GAP;
    localparam int unsigned GW   = $clog2(GMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CGAP,
        S_WGAP
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      code_q, code_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovl_q, ovl_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            pend_q, pend_d;
    logic [7:0]      pchar_q, pchar_d;
    logic            err_q, err_d;

    logic            push_c;
    logic [7:0]      push_data_c;
    logic [7:0]      dec_char_c;
    logic [3:0]      in_vec_c;
    logic            multi_c;
    logic            any_c;

    // ITU table keyed on {symbol count, symbols}; first symbol is the MSB, dash = 1
    function automatic logic [7:0] itu_lookup(input logic [3:0] n, input logic [7:0] c);
        case ({n, c})
            12'h201: itu_lookup = 8'h41; 12'h408: itu_lookup = 8'h42;
            12'h40A: itu_lookup = 8'h43; 12'h304: itu_lookup = 8'h44;
            12'h100: itu_lookup = 8'h45; 12'h402: itu_lookup = 8'h46;
            12'h306: itu_lookup = 8'h47; 12'h400: itu_lookup = 8'h48;
            12'h200: itu_lookup = 8'h49; 12'h407: itu_lookup = 8'h4A;
            12'h305: itu_lookup = 8'h4B; 12'h404: itu_lookup = 8'h4C;
            12'h203: itu_lookup = 8'h4D; 12'h202: itu_lookup = 8'h4E;
            12'h307: itu_lookup = 8'h4F; 12'h406: itu_lookup = 8'h50;
            12'h40D: itu_lookup = 8'h51; 12'h302: itu_lookup = 8'h52;
            12'h300: itu_lookup = 8'h53; 12'h101: itu_lookup = 8'h54;
            12'h301: itu_lookup = 8'h55; 12'h401: itu_lookup = 8'h56;
            12'h303: itu_lookup = 8'h57; 12'h409: itu_lookup = 8'h58;
            12'h40B: itu_lookup = 8'h59; 12'h40C: itu_lookup = 8'h5A;
            12'h51F: itu_lookup = 8'h30; 12'h50F: itu_lookup = 8'h31;
            12'h507: itu_lookup = 8'h32; 12'h503: itu_lookup = 8'h33;
            12'h501: itu_lookup = 8'h34; 12'h500: itu_lookup = 8'h35;
            12'h510: itu_lookup = 8'h36; 12'h518: itu_lookup = 8'h37;
            12'h51C: itu_lookup = 8'h38; 12'h51E: itu_lookup = 8'h39;
            default: itu_lookup = UNKNOWN_CHAR;
        endcase
    endfunction

    assign dec_char_c = ovl_q ? UNKNOWN_CHAR : itu_lookup(cnt_q, code_q);
    assign in_vec_c   = {dot_inp, dash_inp, char_space_inp, word_space_inp};
    assign multi_c    = (in_vec_c & (in_vec_c - 4'd1)) != 4'd0;
    assign any_c      = in_vec_c != 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= 8'h00;
            cnt_q   <= '0;
            ovl_q   <= 1'b0;
            gap_q   <= '0;
            pend_q  <= 1'b0;
            pchar_q <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            ovl_q   <= ovl_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            pchar_q <= pchar_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        ovl_d       = ovl_q;
        gap_d       = gap_q;
        pend_d      = pend_q;
        pchar_d     = pchar_q;
        err_d       = 1'b0;
        push_c      = 1'b0;
        push_data_c = 8'h00;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (multi_c) begin
                    err_d = 1'b1;
                end else if (dot_inp || dash_inp) begin
                    if (cnt_q == CW'(MAX_SYMS)) begin
                        ovl_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        code_d  = {code_q[6:0], dash_inp};
                        cnt_d   = cnt_q + CW'(1);
                        state_d = S_COLLECT;
                    end
                end else if (char_space_inp) begin
                    if (state_q == S_COLLECT) begin
                        state_d = S_CGAP;
                        gap_d   = GW'(CHAR_GAP - 1);
                    end
                end else if (word_space_inp) begin
                    state_d = S_WGAP;
                    gap_d   = GW'(WORD_GAP - 1);
                    // Held character is latched here and pushed on the following edge
                    if (state_q == S_COLLECT) begin
                        pend_d  = 1'b1;
                        pchar_d = dec_char_c;
                        code_d  = 8'h00;
                        cnt_d   = '0;
                        ovl_d   = 1'b0;
                    end
                end
            end
            S_CGAP: begin
                err_d = any_c;
                if (gap_q == '0) begin
                    push_c      = 1'b1;
                    push_data_c = dec_char_c;
                    state_d     = S_IDLE;
                    code_d      = 8'h00;
                    cnt_d       = '0;
                    ovl_d       = 1'b0;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_WGAP: begin
                err_d = any_c;
                if (pend_q) begin
                    push_c      = 1'b1;
                    push_data_c = pchar_q;
                    pend_d      = 1'b0;
                end
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (!pend_q) begin
                    push_c      = 1'b1;
                    push_data_c = 8'h20;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic          pop_c;
    logic          full_c;
    logic          do_push_c;

    assign pop_c     = (level_q != '0) && sout_ready;
    assign full_c    = level_q == LW'(FIFO_DEPTH);
    assign do_push_c = push_c && (!full_c || pop_c);

    // Output FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push_c) wr_q <= wr_q + AW'(1);
            if (pop_c)     rd_q <= rd_q + AW'(1);
            if (do_push_c && !pop_c)      level_q <= level_q + LW'(1);
            else if (!do_push_c && pop_c) level_q <= level_q - LW'(1);
            if (push_c && full_c && !pop_c) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_q] <= push_data_c;
    end

    assign sout         = (level_q != '0) ? mem_q[rd_q] : 8'h00;
    assign sout_valid   = level_q != '0;
    assign fifo_level   = level_q;
    assign err_protocol = err_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_morse_decoder_fifo.sv
// Self-checking bench for morse_decoder_fifo: directed scenarios plus a randomized
// character stream scored against a string-table Morse model.
module tb_morse_decoder_fifo;

    localparam int unsigned CHAR_GAP = 3;
    localparam int unsigned WORD_GAP = 7;
    localparam int unsigned MAX_SYMS = 5;

    logic       clk;
    logic       rst;
    logic       dot_inp, dash_inp, char_space_inp, word_space_inp;
    logic [7:0] sout;
    logic       sout_valid;
    logic       sout_ready;
    logic [2:0] fifo_level;
    logic       err_protocol;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    string morse_tbl [0:35] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-",
        "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---", "...--", "....-",
        ".....", "-....", "--...", "---..", "----."};

    morse_decoder_fifo dut (
        .clk(clk), .rst(rst),
        .dot_inp(dot_inp), .dash_inp(dash_inp),
        .char_space_inp(char_space_inp), .word_space_inp(word_space_inp),
        .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
        .fifo_level(fifo_level), .err_protocol(err_protocol), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_decode(input string p);
        if (p.len() > int'(MAX_SYMS)) return 8'h3F;
        for (int i = 0; i < 36; i++)
            if (p == morse_tbl[i]) return (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
        return 8'h3F;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic d, input logic da, input logic c, input logic w);
        dot_inp = d; dash_inp = da; char_space_inp = c; word_space_inp = w;
        tick();
        dot_inp = 1'b0; dash_inp = 1'b0; char_space_inp = 1'b0; word_space_inp = 1'b0;
    endtask

    task automatic send_pattern(input string p);
        for (int i = 0; i < p.len(); i++) begin
            if (p[i] == 8'h2D) pulse(1'b0, 1'b1, 1'b0, 1'b0);
            else               pulse(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Returns number of edges until sout_valid rises (bounded)
    task automatic wait_valid(output int k);
        k = 0;
        while (!sout_valid && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sout_ready = 1'b0;
        dot_inp = 1'b0; dash_inp = 1'b0; char_space_inp = 1'b0; word_space_inp = 1'b0;
        tick(); tick();
        total++; if (sout !== 8'h00) begin bad++; $display("FAIL reset_sout got=%h exp=00", sout); end
        total++; if (sout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sout_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_protocol); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_char_a;
        int k;
        sout_ready = 1'b0;
        send_pattern(".-");
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(k);
        total++; if (k != int'(CHAR_GAP)) begin bad++; $display("FAIL a_latency got=%0d exp=%0d", k, CHAR_GAP); end
        total++; if (sout !== 8'h41) begin bad++; $display("FAIL a_char got=%h exp=41", sout); end
        sout_ready = 1'b1;
        tick();
        sout_ready = 1'b0;
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL a_level got=%0d exp=0", fifo_level); end
        total++; if (sout !== 8'h00) begin bad++; $display("FAIL a_sout_empty got=%h exp=00", sout); end
    endtask

    task automatic test_sos_word;
        int k;
        string pats [3] = '{"...", "---", "..."};
        logic [7:0] exp_c [3] = '{8'h53, 8'h4F, 8'h53};
        sout_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_pattern(pats[i]);
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
            wait_valid(k);
            total++; if (sout !== exp_c[i]) begin bad++; $display("FAIL sos_char%0d got=%h exp=%h", i, sout, exp_c[i]); end
            tick();
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(k);
        total++; if (k != int'(WORD_GAP)) begin bad++; $display("FAIL sos_space_latency got=%0d exp=%0d", k, WORD_GAP); end
        total++; if (sout !== 8'h20) begin bad++; $display("FAIL sos_space got=%h exp=20", sout); end
        tick();
        // Held symbols at word_space: char one edge later, space after the full word gap
        send_pattern(".");
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(k);
        total++; if (k != 1 || sout !== 8'h45) begin bad++; $display("FAIL ws_char got=%h@%0d exp=45@1", sout, k); end
        tick();
        begin
            int k2;
            wait_valid(k2);
            k = k + 1 + k2;
        end
        total++; if (k != int'(WORD_GAP) || sout !== 8'h20) begin bad++; $display("FAIL ws_space got=%h@%0d exp=20@%0d", sout, k, WORD_GAP); end
        tick();
    endtask

    task automatic test_overlong;
        int k;
        sout_ready = 1'b1;
        send_pattern(".....");
        total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL ovl_err_early got=%b exp=0", err_protocol); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL ovl_err got=%b exp=1", err_protocol); end
        tick();
        total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL ovl_err_pulse got=%b exp=0", err_protocol); end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(k);
        total++; if (sout !== 8'h3F) begin bad++; $display("FAIL ovl_char got=%h exp=3F", sout); end
        tick();
        send_pattern(".-..-");
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(k);
        total++; if (sout !== 8'h3F) begin bad++; $display("FAIL unmapped_char got=%h exp=3F", sout); end
        tick();
    endtask

    task automatic test_backpressure;
        string pats [5] = '{".-", "-...", "-.-.", "-..", "."};
        sout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_pattern(pats[i]);
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (CHAR_GAP) tick();
            if (i == 3) begin
                total++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL bp_full got=%0d/%b exp=4/0", fifo_level, overflow); end
            end
        end
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b exp=1", overflow); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (sout !== 8'h41) begin bad++; $display("FAIL bp_stable%0d got=%h exp=41", i, sout); end
        end
        sout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (sout !== 8'(8'h41 + i) || sout_valid !== 1'b1) begin bad++; $display("FAIL bp_drain%0d got=%h exp=%h", i, sout, 8'(8'h41 + i)); end
            tick();
        end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL bp_empty got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_reset_wgap;
        int k;
        bit seen;
        sout_ready = 1'b1;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        do_reset();
        total++; if (sout !== 8'h00 || sout_valid !== 1'b0) begin bad++; $display("FAIL rstw_out got=%h/%b exp=00/0", sout, sout_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstw_ovf got=%b exp=0", overflow); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sout_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstw_no_space got=%b exp=0", seen); end
        send_pattern(".");
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(k);
        total++; if (sout !== 8'h45) begin bad++; $display("FAIL rstw_e got=%h exp=45", sout); end
        tick();
    endtask

    task automatic test_violations;
        int k;
        do_reset();
        sout_ready = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL multi_err got=%b exp=1", err_protocol); end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        total++; if (err_protocol !== 1'b0) begin bad++; $display("FAIL multi_err_pulse got=%b exp=0", err_protocol); end
        wait_valid(k);
        total++; if (sout !== 8'h45) begin bad++; $display("FAIL multi_count got=%h exp=45", sout); end
        tick();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (err_protocol !== 1'b1) begin bad++; $display("FAIL cgap_err got=%b exp=1", err_protocol); end
        wait_valid(k);
        k = k + 1;
        total++; if (k != int'(CHAR_GAP) || sout !== 8'h45) begin bad++; $display("FAIL cgap_char got=%h@%0d exp=45@%0d", sout, k, CHAR_GAP); end
        tick();
    endtask

    task automatic test_random;
        logic [7:0] exp_q [$];
        bit drv_done;
        drv_done = 1'b0;
        do_reset();
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    string p;
                    int len;
                    p = "";
                    len = $urandom_range(1, 6);
                    for (int s = 0; s < len; s++) p = {p, ($urandom_range(0, 1) != 0) ? "-" : "."};
                    for (int s = 0; s < len; s++) begin
                        if (p[s] == 8'h2D) pulse(1'b0, 1'b1, 1'b0, 1'b0);
                        else               pulse(1'b1, 1'b0, 1'b0, 1'b0);
                        repeat ($urandom_range(0, 2)) tick();
                    end
                    exp_q.push_back(model_decode(p));
                    if ($urandom_range(0, 3) == 0) begin
                        pulse(1'b0, 1'b0, 1'b0, 1'b1);
                        exp_q.push_back(8'h20);
                        repeat (WORD_GAP) tick();
                    end else begin
                        pulse(1'b0, 1'b0, 1'b1, 1'b0);
                        repeat (CHAR_GAP) tick();
                    end
                    repeat ($urandom_range(0, 2)) tick();
                end
                drv_done = 1'b1;
            end
            begin
                int guard;
                guard = 0;
                while (!(drv_done && exp_q.size() == 0) && guard < 5000) begin
                    sout_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (sout_valid && sout_ready) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++; $display("FAIL rnd_extra got=%h exp=none", sout);
                        end else begin
                            if (sout !== exp_q[0]) begin bad++; $display("FAIL rnd_char got=%h exp=%h", sout, exp_q[0]); end
                            void'(exp_q.pop_front());
                        end
                    end
                    @(posedge clk);
                    #1;
                    guard++;
                end
            end
        join
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_pending got=%0d exp=0", exp_q.size()); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rnd_ovf got=%b exp=0", overflow); end
        sout_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_char_a();
        test_sos_word();
        test_overlong();
        test_backpressure();
        test_reset_wgap();
        test_violations();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
